bist_scan_controller: RTL

//  Parametrised test-per-scan BIST controller for N parallel scan chains of the CUT.

---
 rtl/bist_pkg.sv | 21 ++
 rtl/bist_misr.sv | 43 ++++
 rtl/bist_scan_controller.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// Shared definitions for the scan BIST controller slice.
// Holds the controller state encoding and the default LFSR / MISR polynomials
// so the controller and its MISR agree on one set of defaults.
package bist_pkg;

  // Controller states: idle, chain shift (load/unload), one-cycle capture, run finished
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } bist_state_t;

  // Default 16-bit Fibonacci LFSR feedback taps and start value (start must be nonzero)
  localparam logic [15:0] DEFAULT_LFSR_TAPS = 16'hB400;
  localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;

  // Default MISR feedback polynomial (CCITT)
  localparam logic [15:0] DEFAULT_MISR_POLY = 16'h1021;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register compacting the parallel scan chain outputs.
// Ports:
//   clock  - system clock, posedge
//   reset  - synchronous active-high reset, clears the signature
//   clr    - synchronous clear at the start of a run
//   en     - fold din into the signature this cycle
//   din    - one bit per scan chain
//   sig    - current signature
module bist_misr
  import bist_pkg::*;
#(
  parameter int                MISR_W    = 16,
  parameter logic [MISR_W-1:0] MISR_POLY = DEFAULT_MISR_POLY,
  parameter int                N_CHAINS  = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clr,
  input  logic                en,
  input  logic [N_CHAINS-1:0] din,
  output logic [MISR_W-1:0]   sig
);

  logic [MISR_W-1:0] din_ext;

  // Chain bits enter at the low end of the register; the rest of the word is zero.
  // Built procedurally so N_CHAINS == MISR_W needs no zero-width replication.
  always_comb begin
    din_ext = '0;
    din_ext[N_CHAINS-1:0] = din;
  end

  // Galois-style shift: shift left, fold the polynomial back in when the MSB drops
  // out, then xor the new chain bits on top.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? MISR_POLY : '0) ^ din_ext;
    end
  end

endmodule

// File: rtl/bist_scan_controller.sv
// Test-per-scan BIST controller for N_CHAINS parallel scan chains.
// An LFSR feeds pseudo-random data into the chains, the FSM sequences shift and
// capture cycles, and a MISR compacts the unloaded responses for comparison
// against GOLDEN_SIG.
// Ports:
//   clock       - system clock, posedge
//   reset       - synchronous active-high reset
//   bist_start  - level request, the run continues only while it is high
//   scan_out    - serial outputs of the CUT chains
//   scan_in     - serial inputs to the CUT chains
//   scan_en     - 1 = shift, 0 = functional capture
//   bist_active - high in SHIFT and CAPTURE
//   bist_end    - run complete, held until bist_start drops
//   pass_nfail  - signature matched GOLDEN_SIG, meaningful only with bist_end
//   signature   - current MISR contents
module bist_scan_controller
  import bist_pkg::*;
#(
  parameter int                N_CHAINS   = 2,
  parameter int                CHAIN_LEN  = 8,
  parameter int                N_PATTERNS = 16,
  parameter int                LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS  = DEFAULT_LFSR_TAPS,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = DEFAULT_LFSR_SEED,
  parameter int                MISR_W     = 16,
  parameter logic [MISR_W-1:0] MISR_POLY  = DEFAULT_MISR_POLY,
  parameter logic [MISR_W-1:0] GOLDEN_SIG = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                bist_start,
  input  logic [N_CHAINS-1:0] scan_out,
  output logic [N_CHAINS-1:0] scan_in,
  output logic                scan_en,
  output logic                bist_active,
  output logic                bist_end,
  output logic                pass_nfail,
  output logic [MISR_W-1:0]   signature
);

  // A one-flop chain still needs a one-bit shift counter
  localparam int CNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int PAT_W = $clog2(N_PATTERNS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [PAT_W-1:0] LAST_PAT = PAT_W'(N_PATTERNS);

  bist_state_t       state;
  bist_state_t       next_state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [PAT_W-1:0]  pat_idx;
  logic [LFSR_W-1:0] lfsr;
  logic              last_bit;
  logic              start_run;
  logic              misr_en;

  assign last_bit  = (bit_cnt == LAST_BIT);
  assign start_run = (state == IDLE) && bist_start;
  // The first load shifts out whatever the chains held before the run, so it is not compacted
  assign misr_en   = (state == SHIFT) && (pat_idx != '0);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Dropping bist_start aborts any active run; after the last
  // unload (pat_idx already at N_PATTERNS) the run goes to DONE instead of capturing.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (bist_start) next_state = SHIFT;
      end
      SHIFT: begin
        if (!bist_start)  next_state = IDLE;
        else if (last_bit) next_state = (pat_idx < LAST_PAT) ? CAPTURE : DONE;
      end
      CAPTURE: begin
        next_state = bist_start ? SHIFT : IDLE;
      end
      DONE: begin
        if (!bist_start) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode. Chains sit in shift mode with zero input whenever no run is shifting.
  always_comb begin
    scan_en     = 1'b1;
    scan_in     = '0;
    bist_active = 1'b0;
    bist_end    = 1'b0;
    pass_nfail  = 1'b0;
    unique case (state)
      SHIFT: begin
        bist_active = 1'b1;
        scan_in     = lfsr[N_CHAINS-1:0];
      end
      CAPTURE: begin
        bist_active = 1'b1;
        scan_en     = 1'b0;
      end
      DONE: begin
        bist_end   = 1'b1;
        pass_nfail = (signature == GOLDEN_SIG);
      end
      default: begin
      end
    endcase
  end

  // Pattern generator and counters. The LFSR only moves while shifting, so the
  // data stream continues unbroken across captures; a new run restarts from the seed.
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr    <= LFSR_SEED;
      bit_cnt <= '0;
      pat_idx <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bist_start) begin
            lfsr    <= LFSR_SEED;
            bit_cnt <= '0;
            pat_idx <= '0;
          end
        end
        SHIFT: begin
          lfsr    <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
          bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        end
        CAPTURE: begin
          pat_idx <= pat_idx + 1'b1;
          bit_cnt <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  // Response compactor, cleared on the edge that launches a run so an aborted
  // run's signature stays visible until the next start
  bist_misr #(
    .MISR_W   (MISR_W),
    .MISR_POLY(MISR_POLY),
    .N_CHAINS (N_CHAINS)
  ) u_misr (
    .clock(clock),
    .reset(reset),
    .clr  (start_run),
    .en   (misr_en),
    .din  (scan_out),
    .sig  (signature)
  );

endmodule
